// File: rtl/reaction_ctrl_if.sv
// Signal bundle between reaction_ctrl and its environment (delay stage, buttons, display).
// master: the controller side; slave: the surrounding logic driving its inputs.
interface reaction_ctrl_if #(
  parameter int unsigned LED_W  = 10,
  parameter int unsigned DIGITS = 4
);
  logic                  tick_ms;
  logic                  start;
  logic                  stop;
  logic                  timeout;
  logic                  trigger;
  logic [LED_W-1:0]      led;
  logic [4*DIGITS-1:0]   time_bcd;
  logic                  valid;
  logic                  too_early;
  logic [4*DIGITS-1:0]   best_bcd;

  modport master (
    input  tick_ms, start, stop, timeout,
    output trigger, led, time_bcd, valid, too_early, best_bcd
  );

  modport slave (
    output tick_ms, start, stop, timeout,
    input  trigger, led, time_bcd, valid, too_early, best_bcd
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer game controller: arms the delay stage, lights LEDs, counts ms in BCD.
// Define REACTION_CTRL_BEST_EN to track the best (minimum) completed time.
module reaction_ctrl #(
  parameter int unsigned LED_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  reaction_ctrl_if.master bus
);
  localparam int unsigned TW = 4 * DIGITS;
  localparam logic [TW-1:0] AllNines = {DIGITS{4'h9}};

  typedef enum logic [2:0] {StIdle, StArmed, StGo, StDone, StEarly} state_e;

  state_e           state_q;
  logic             start_q, stop_q;
  logic             trigger_q, valid_q, too_early_q;
  logic [LED_W-1:0] led_q;
  logic [TW-1:0]    time_q;
  logic             start_rise, stop_rise;
  logic [TW-1:0]    time_final;

  // Saturating BCD increment: all-9s holds instead of wrapping.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    if (v == AllNines) return v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_rise = bus.start & ~start_q;
    stop_rise  = bus.stop & ~stop_q;
    time_final = bus.tick_ms ? bcd_inc(time_q) : time_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      trigger_q   <= 1'b0;
      valid_q     <= 1'b0;
      too_early_q <= 1'b0;
      led_q       <= '0;
      time_q      <= '0;
    end else begin
      start_q   <= bus.start;
      stop_q    <= bus.stop;
      trigger_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StEarly: begin
          if (start_rise) begin
            state_q     <= StArmed;
            trigger_q   <= 1'b1;
            time_q      <= '0;
            valid_q     <= 1'b0;
            too_early_q <= 1'b0;
          end
        end
        StArmed: begin
          // A stop press beats a coincident timeout.
          if (stop_rise) begin
            state_q     <= StEarly;
            too_early_q <= 1'b1;
          end else if (bus.timeout) begin
            state_q <= StGo;
            led_q   <= '1;
          end
        end
        StGo: begin
          time_q <= time_final;
          if (stop_rise) begin
            state_q <= StDone;
            led_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.led       = led_q;
  assign bus.time_bcd  = time_q;
  assign bus.valid     = valid_q;
  assign bus.too_early = too_early_q;

`ifdef REACTION_CTRL_BEST_EN
  logic [TW-1:0] best_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= AllNines;
    end else if (state_q == StGo && stop_rise && time_final < best_q) begin
      best_q <= time_final;
    end
  end

  assign bus.best_bcd = best_q;
`else
  assign bus.best_bcd = AllNines;
`endif
endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with randomized rounds and a decimal reference model.
module tb_reaction_ctrl;
  localparam int unsigned LED_W  = 10;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned TW     = 4 * DIGITS;
  localparam int          MAXV   = 9999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   best_dec = MAXV;

  reaction_ctrl_if #(.LED_W(LED_W), .DIGITS(DIGITS)) bus ();

  reaction_ctrl #(.LED_W(LED_W), .DIGITS(DIGITS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Decimal value to packed BCD via plain division.
  function automatic logic [TW-1:0] to_bcd(input int v);
    logic [TW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_round(input int ticks);
`ifdef REACTION_CTRL_BEST_EN
    if (sat(ticks) < best_dec) best_dec = sat(ticks);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.tick_ms = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.timeout = 1'b0;
    rst_n       = 1'b0;
    cyc();
    cyc();
    rst_n    = 1'b1;
    best_dec = MAXV;
    cyc();
  endtask

  task automatic pulse_start(output int trig);
    trig      = 0;
    bus.start = 1'b1;
    cyc();
    if (bus.trigger === 1'b1) trig++;
    bus.start = 1'b0;
    repeat (3) begin
      cyc();
      if (bus.trigger === 1'b1) trig++;
    end
  endtask

  // From ARMED: timeout after delay cycles, then issue ticks until stop.
  task automatic run_go(input int ticks, input int delay, input int gap_pct,
                        input bit stop_on_tick, output int led_err);
    int cnt, target;
    led_err = 0;
    repeat (delay) cyc();
    bus.timeout = 1'b1;
    cyc();
    bus.timeout = 1'b0;
    if (bus.led !== {LED_W{1'b1}}) led_err++;
    cnt    = 0;
    target = stop_on_tick ? ticks - 1 : ticks;
    while (cnt < target) begin
      bus.tick_ms = ($urandom_range(99) >= gap_pct);
      if (bus.tick_ms) cnt++;
      cyc();
      if (bus.led !== {LED_W{1'b1}}) led_err++;
    end
    bus.tick_ms = stop_on_tick;
    bus.stop    = 1'b1;
    cyc();
    bus.tick_ms = 1'b0;
    bus.stop    = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.trigger !== 1'b0) begin
      n_fail++; $display("FAIL reset_trigger: got %b expected 0", bus.trigger);
    end
    n_checks++;
    if (bus.led !== '0) begin
      n_fail++; $display("FAIL reset_led: got %h expected 0", bus.led);
    end
    n_checks++;
    if (bus.time_bcd !== '0) begin
      n_fail++; $display("FAIL reset_time: got %h expected 0", bus.time_bcd);
    end
    n_checks++;
    if (bus.valid !== 1'b0 || bus.too_early !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got valid=%b too_early=%b expected 0/0",
                         bus.valid, bus.too_early);
    end
    n_checks++;
    if (bus.best_bcd !== to_bcd(MAXV)) begin
      n_fail++; $display("FAIL reset_best: got %h expected %h", bus.best_bcd, to_bcd(MAXV));
    end
  endtask

  task automatic test_normal();
    int trig, led_err;
    logic [TW-1:0] held;
    apply_reset();
    pulse_start(trig);
    n_checks++;
    if (trig != 1) begin
      n_fail++; $display("FAIL normal_trigger_len: got %0d cycles expected 1", trig);
    end
    run_go(123, 16, 0, 1'b0, led_err);
    model_round(123);
    n_checks++;
    if (led_err != 0) begin
      n_fail++; $display("FAIL normal_led_go: got %0d bad cycles expected 0", led_err);
    end
    n_checks++;
    if (bus.time_bcd !== 16'h0123 || bus.valid !== 1'b1 || bus.led !== '0) begin
      n_fail++; $display("FAIL normal_result: got time=%h valid=%b led=%h expected 0123/1/000",
                         bus.time_bcd, bus.valid, bus.led);
    end
    n_checks++;
    if (bus.best_bcd !== to_bcd(best_dec)) begin
      n_fail++; $display("FAIL normal_best: got %h expected %h", bus.best_bcd, to_bcd(best_dec));
    end
    // Ticks and a stray timeout in DONE must not disturb the result.
    held        = bus.time_bcd;
    bus.tick_ms = 1'b1;
    bus.timeout = 1'b1;
    cyc();
    bus.timeout = 1'b0;
    repeat (4) cyc();
    bus.tick_ms = 1'b0;
    n_checks++;
    if (bus.time_bcd !== held || bus.valid !== 1'b1 || bus.led !== '0) begin
      n_fail++; $display("FAIL done_hold: got time=%h valid=%b led=%h expected %h/1/000",
                         bus.time_bcd, bus.valid, bus.led, held);
    end
  endtask

  task automatic test_early();
    int trig;
    apply_reset();
    pulse_start(trig);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    cyc();
    n_checks++;
    if (bus.too_early !== 1'b1 || bus.time_bcd !== '0 || bus.led !== '0 || bus.valid !== 1'b0)
    begin
      n_fail++; $display("FAIL early_flags: got too_early=%b time=%h led=%h valid=%b exp 1/0/0/0",
                         bus.too_early, bus.time_bcd, bus.led, bus.valid);
    end
    bus.timeout = 1'b1;
    cyc();
    bus.timeout = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (bus.led !== '0 || bus.too_early !== 1'b1) begin
      n_fail++; $display("FAIL early_late_timeout: got led=%h too_early=%b expected 000/1",
                         bus.led, bus.too_early);
    end
    pulse_start(trig);
    n_checks++;
    if (trig != 1 || bus.too_early !== 1'b0) begin
      n_fail++; $display("FAIL early_restart: got trig=%0d too_early=%b expected 1/0",
                         trig, bus.too_early);
    end
  endtask

  task automatic test_saturation();
    int trig, led_err;
    apply_reset();
    pulse_start(trig);
    run_go(10005, 2, 0, 1'b0, led_err);
    model_round(10005);
    n_checks++;
    if (bus.time_bcd !== 16'h9999 || bus.valid !== 1'b1) begin
      n_fail++; $display("FAIL saturation: got time=%h valid=%b expected 9999/1",
                         bus.time_bcd, bus.valid);
    end
  endtask

  task automatic test_simultaneous();
    int trig, led_err;
    apply_reset();
    pulse_start(trig);
    run_go(42, 3, 0, 1'b1, led_err);
    model_round(42);
    n_checks++;
    if (bus.time_bcd !== 16'h0042 || bus.valid !== 1'b1) begin
      n_fail++; $display("FAIL sim_tick_stop: got time=%h valid=%b expected 0042/1",
                         bus.time_bcd, bus.valid);
    end
    pulse_start(trig);
    bus.stop    = 1'b1;
    bus.timeout = 1'b1;
    cyc();
    bus.stop    = 1'b0;
    bus.timeout = 1'b0;
    cyc();
    n_checks++;
    if (bus.too_early !== 1'b1 || bus.led !== '0 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL sim_stop_timeout: got too_early=%b led=%h valid=%b expected 1/000/0",
                         bus.too_early, bus.led, bus.valid);
    end
  endtask

  task automatic test_restart_reset();
    int trig, led_err;
    apply_reset();
    pulse_start(trig);
    run_go(7, 1, 0, 1'b0, led_err);
    pulse_start(trig);
    n_checks++;
    if (trig != 1 || bus.time_bcd !== '0 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL restart: got trig=%0d time=%h valid=%b expected 1/0000/0",
                         trig, bus.time_bcd, bus.valid);
    end
    bus.timeout = 1'b1;
    cyc();
    bus.timeout = 1'b0;
    bus.tick_ms = 1'b1;
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.led !== '0 || bus.time_bcd !== '0 || bus.valid !== 1'b0 || bus.trigger !== 1'b0 ||
        bus.too_early !== 1'b0 || bus.best_bcd !== to_bcd(MAXV)) begin
      n_fail++; $display("FAIL async_reset: got led=%h time=%h valid=%b trig=%b early=%b best=%h",
                         bus.led, bus.time_bcd, bus.valid, bus.trigger, bus.too_early,
                         bus.best_bcd);
    end
    bus.tick_ms = 1'b0;
    cyc();
    rst_n    = 1'b1;
    best_dec = MAXV;
    cyc();
  endtask

  task automatic test_best();
    int trig, led_err;
    int seq[4] = '{250, -1, 180, 300};
    apply_reset();
    n_checks++;
    if (bus.best_bcd !== to_bcd(best_dec)) begin
      n_fail++; $display("FAIL best_init: got %h expected %h", bus.best_bcd, to_bcd(best_dec));
    end
    foreach (seq[i]) begin
      pulse_start(trig);
      if (seq[i] < 0) begin
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        cyc();
      end else begin
        run_go(seq[i], 2, 25, 1'b0, led_err);
        model_round(seq[i]);
      end
      n_checks++;
      if (bus.best_bcd !== to_bcd(best_dec)) begin
        n_fail++; $display("FAIL best_round%0d: got %h expected %h", i, bus.best_bcd,
                           to_bcd(best_dec));
      end
    end
  endtask

  task automatic test_random();
    int trig, led_err, ticks, exp_ticks;
    bit early, on_tick;
    apply_reset();
    for (int r = 0; r < 8; r++) begin
      early   = ($urandom_range(99) < 20);
      ticks   = $urandom_range(400, 1);
      on_tick = $urandom_range(1);
      pulse_start(trig);
      if (early) begin
        repeat ($urandom_range(5)) cyc();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        cyc();
        n_checks++;
        if (bus.too_early !== 1'b1 || bus.time_bcd !== '0 || bus.valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_early%0d: got early=%b time=%h valid=%b expected 1/0/0",
                             r, bus.too_early, bus.time_bcd, bus.valid);
        end
      end else begin
        run_go(ticks, $urandom_range(10), 30, on_tick, led_err);
        exp_ticks = ticks;
        model_round(exp_ticks);
        n_checks++;
        if (bus.time_bcd !== to_bcd(sat(exp_ticks)) || bus.valid !== 1'b1 || led_err != 0) begin
          n_fail++; $display("FAIL rand_round%0d: got time=%h valid=%b led_err=%0d exp %h/1/0",
                             r, bus.time_bcd, bus.valid, led_err, to_bcd(sat(exp_ticks)));
        end
      end
      n_checks++;
      if (bus.best_bcd !== to_bcd(best_dec)) begin
        n_fail++; $display("FAIL rand_best%0d: got %h expected %h", r, bus.best_bcd,
                           to_bcd(best_dec));
      end
    end
  endtask

  initial begin
    bus.tick_ms = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.timeout = 1'b0;
    test_reset();
    test_normal();
    test_early();
    test_saturation();
    test_simultaneous();
    test_restart_reset();
    test_best();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Game controller for the reaction-timer experiment; sits directly downstream of the programmable delay stage.
- Drives that stage's trigger input and consumes its timeout pulse.
- Start press: arms the delay stage; on timeout, lights the LEDs.
- Then counts milliseconds in BCD until the stop press, and holds the result for the 7-segment display stage.

Parameters:
- LED_W, 10, width of the LED bar driven during the GO phase.
- DIGITS, 4, number of BCD digits in the reaction-time counter (result width 4*DIGITS).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick_ms  in  1  one-cycle enable pulse, once per millisecond.
- start  in  1  debounced, synchronised start button (level, active high).
- stop  in  1  debounced, synchronised stop button (level, active high).
- timeout  in  1  one-cycle completion pulse from the delay stage.
- trigger  out  1  one-cycle request pulse to the delay stage.
- led  out  LED_W  LED bar; all ones in GO, else all zeros.
- time_bcd  out  4*DIGITS  reaction time, packed BCD, digit 0 in LSBs.
- valid  out  1  high while time_bcd holds a completed measurement.
- too_early  out  1  high after stop was pressed before the LEDs lit.
- best_bcd  out  4*DIGITS  best (minimum) valid time; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - trigger=0, led=0, time_bcd=0, valid=0, too_early=0.
  - Edge-detect registers = 0.
  - best_bcd = all digits 9.
- Edge detection:
  - start_rise = start & ~start_q; stop_rise = stop & ~stop_q.
  - start_q and stop_q are registered every cycle.
- States: IDLE, ARMED, GO, DONE, EARLY.
- IDLE:
  - start_rise -> ARMED.
  - Same edge: trigger=1 for exactly one cycle, time_bcd cleared, valid=0, too_early=0.
- ARMED:
  - Waits for timeout.
  - timeout -> GO; led=all ones on the next cycle.
  - stop_rise -> EARLY; too_early=1.
  - stop_rise and timeout in the same cycle: stop wins (EARLY).
  - start_rise is ignored.
- GO:
  - Each tick_ms increments time_bcd by 1 as a BCD counter: digit rolls 9->0 and carries to the next digit.
  - Saturates at all-9s and holds there; no wrap.
  - stop_rise -> DONE; led=0, valid=1.
  - tick_ms and stop_rise in the same cycle: the tick is counted, then the value is frozen.
  - start_rise is ignored.
- DONE:
  - time_bcd and valid are held.
  - start_rise -> ARMED with the IDLE-exit actions (trigger pulse, clear time_bcd, valid=0).
- EARLY:
  - time_bcd=0, led=0, too_early held.
  - start_rise -> ARMED with the IDLE-exit actions; too_early cleared.
- Stray pulses:
  - The delay stage has no reset.
  - A timeout pulse arriving in IDLE, GO, DONE or EARLY is ignored.
  - Only one trigger is issued per round.
- Outputs are registered; no combinational path from any input to any output.
- Reset asserted mid-round (any state): immediate return to IDLE with reset values. best_bcd also resets.

Optional Feature:
- Macro: REACTION_CTRL_BEST_EN.
- Defined:
  - On each GO->DONE transition, if time_bcd (after the final tick) < best_bcd, best_bcd takes the new value.
  - Comparison is unsigned on the packed BCD vector, which is order-preserving because every digit ≤ 9.
  - EARLY rounds never update best_bcd.
- Not defined: best_bcd is tied to constant all-9s; no comparator or register is synthesised.

Test Plan:
- Normal round:
  - Stimulus: reset, start pulse; timeout 20 cycles later; tick_ms every cycle; stop after 123 ticks.
  - Required: trigger high exactly 1 cycle; led=10'h3FF during GO; time_bcd=16'h0123, valid=1, led=0 after stop.
- Early press:
  - Stimulus: start, then stop before timeout; later a timeout pulse arrives.
  - Required: too_early=1, time_bcd=0, led stays 0; the late timeout is ignored and state stays EARLY.
- Saturation:
  - Stimulus: GO with 10005 ticks before stop.
  - Required: time_bcd=16'h9999, valid=1, no wrap to 0000.
- Simultaneous events:
  - Case 1: tick_ms and stop_rise on the same cycle at count 0041. Required: result 0042.
  - Case 2: stop_rise and timeout together in ARMED. Required: EARLY.
- Restart and reset:
  - Stimulus: from DONE, start again; check second trigger pulse and time_bcd cleared; then assert rst_n low mid-GO.
  - Required: all outputs at reset values in the same cycle, led=0 immediately.
- REACTION_CTRL_BEST_EN defined:
  - Stimulus: rounds of 0250, early press, 0180, 0300.
  - Required: best_bcd = 9999 -> 0250 -> 0250 -> 0180 -> 0180.
  - With the macro undefined: best_bcd stays 9999 throughout.
